// File: rtl/sobel_pkg.sv
// +-----------------------------------------------------------------------+
// | sobel_pkg : shared mode codes, FSM states and helpers for the filter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package sobel_pkg;

  localparam logic [1:0] MODE_MAG = 2'd0;
  localparam logic [1:0] MODE_GX  = 2'd1;
  localparam logic [1:0] MODE_GY  = 2'd2;
  localparam logic [1:0] MODE_BIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Absolute value clamped to the largest unsigned value of width w.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int unsigned w);
    logic [31:0] mag;
    logic [31:0] lim;
    mag = v[31] ? 32'(-v) : 32'(v);
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_line_buffer.sv
// +-----------------------------------------------------------------------+
// | sobel_line_buffer : one-row pixel delay line, shifts on enable        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sobel_line_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0] o_pix
);

  // Contents need no reset: every frame refills the row before it is used.
  logic [DEPTH-1:0][PIX_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem <= {r_mem[DEPTH-2:0], i_pix};
    end
  end

  assign o_pix = r_mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sobel_stream_filter.sv
// +-----------------------------------------------------------------------+
// | sobel_stream_filter : streaming 3x3 Sobel filter with ready/valid I/O |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int IMG_X_SIZE = 640,
  parameter int IMG_Y_SIZE = 480
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [PIX_W-1:0] threshold_i,
  input  logic [PIX_W-1:0] pixel_i,
  input  logic             pixel_valid_i,
  output logic             pixel_ready_o,
  output logic [PIX_W-1:0] out_pixel_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int XW = $clog2(IMG_X_SIZE);
  localparam int YW = $clog2(IMG_Y_SIZE);
  localparam int SW = PIX_W + 4;

  state_t            r_state, w_next;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [1:0]        r_mode;
  logic [PIX_W-1:0]  r_thr;
  logic [PIX_W-1:0]  r_c0 [3];
  logic [PIX_W-1:0]  r_c1 [3];
  logic [PIX_W-1:0]  r_out_pix;
  logic              r_out_valid, r_out_last;

  logic [PIX_W-1:0]  w_lb1, w_lb2, w_res;
  logic [PIX_W-1:0]  w_col [3];
  logic              w_pix_ready, w_accept, w_out_hs, w_x_end, w_y_end, w_last_in, w_emit;
  logic signed [SW-1:0] w_gx, w_gy;
  logic [SW-1:0]     w_ax, w_ay, w_sum;

  function automatic logic signed [SW-1:0] sx(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  assign w_pix_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready_i);
  assign w_accept    = pixel_valid_i && w_pix_ready;
  assign w_out_hs    = r_out_valid && out_ready_i;
  assign w_x_end     = (r_x == XW'(IMG_X_SIZE - 1));
  assign w_y_end     = (r_y == YW'(IMG_Y_SIZE - 1));
  assign w_last_in   = w_accept && w_x_end && w_y_end;
  assign w_emit      = w_accept && (r_x >= XW'(2)) && (r_y >= YW'(2));

  sobel_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_X_SIZE)) u_lb_prev (
    .clk(clk_i), .i_en(w_accept), .i_pix(pixel_i), .o_pix(w_lb1)
  );
  sobel_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_X_SIZE)) u_lb_prev2 (
    .clk(clk_i), .i_en(w_accept), .i_pix(w_lb1), .o_pix(w_lb2)
  );

  // Right-hand window column is the incoming pixel stacked under its two line-buffer taps.
  assign w_col[0] = w_lb2;
  assign w_col[1] = w_lb1;
  assign w_col[2] = pixel_i;

  assign w_gx = (sx(w_col[0]) + (sx(w_col[1]) <<< 1) + sx(w_col[2]))
              - (sx(r_c0[0])  + (sx(r_c0[1])  <<< 1) + sx(r_c0[2]));
  assign w_gy = (sx(r_c0[2]) + (sx(r_c1[2]) <<< 1) + sx(w_col[2]))
              - (sx(r_c0[0]) + (sx(r_c1[0]) <<< 1) + sx(w_col[0]));
  assign w_ax  = SW'(sat_abs(32'(w_gx), SW));
  assign w_ay  = SW'(sat_abs(32'(w_gy), SW));
  assign w_sum = w_ax + w_ay;

  always_comb begin
    w_res = '0;
    case (r_mode)
      MODE_MAG: w_res = PIX_W'(sat_abs(32'(w_sum), PIX_W));
      MODE_GX:  w_res = PIX_W'(sat_abs(32'(w_ax), PIX_W));
      MODE_GY:  w_res = PIX_W'(sat_abs(32'(w_ay), PIX_W));
      default:  w_res = (w_sum >= SW'(r_thr)) ? '1 : '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_next = ST_RUN;
      ST_RUN:   if (w_last_in) w_next = ST_DRAIN;
      ST_DRAIN: if (w_out_hs && r_out_last) w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x         <= '0;
      r_y         <= '0;
      r_mode      <= '0;
      r_thr       <= '0;
      r_out_pix   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        r_c0[r] <= '0;
        r_c1[r] <= '0;
      end
    end else begin
      if (r_state == ST_IDLE && start_i) begin
        r_mode <= mode_i;
        r_thr  <= threshold_i;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_accept) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_c0[r] <= r_c1[r];
          r_c1[r] <= w_col[r];
        end
      end
      if (w_emit) begin
        r_out_pix   <= w_res;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_in;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign pixel_ready_o = w_pix_ready;
  assign out_pixel_o   = r_out_pix;
  assign out_valid_o   = r_out_valid;
  assign out_last_o    = r_out_last;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = (r_state == ST_DONE);

endmodule

`default_nettype wire
